tile_addr_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 / 80x60 tiled-image address scanner.
- Walks the active pixel raster one pixel per enabled cycle and emits the ROM address of the tile-local texel for each pixel.
- Adds configurable raster and tile geometry, integer pixel replication (scaling), a frame-latched tiling mode (repeat / mirror / single), and raster position flags.
- Sits between the pixel-clock enable from the VGA timing block and the image ROM.

---
 rtl/tile_addr_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_tile_addr_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: walks the active raster one pixel per enabled cycle and
// produces the ROM address of the tile-local texel for each pixel. It supports
// integer pixel/line replication, frame-latched repeat/mirror/single tiling,
// and start-of-frame / end-of-line / end-of-frame flags.
//
// Output handshake: there is no back-pressure. addr_valid is high for exactly
// one cycle after each enabled cycle, and rom_addr/blank/sof/eol/eof belong to
// that pixel. On all other cycles addr_valid, sof, eol and eof are 0, while
// rom_addr and blank keep their previous values.
module tile_addr_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int TILE_W   = 80,
    parameter int TILE_H   = 60,
    parameter int SCALE_X  = 1,
    parameter int SCALE_Y  = 1,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              addr_valid,
    output logic              blank,
    output logic              sof,
    output logic              eol,
    output logic              eof
);

    localparam int XW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
    localparam int UW  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int VW  = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [XW-1:0]     X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [SXW-1:0]    SX_LAST  = SXW'(SCALE_X - 1);
    localparam logic [SYW-1:0]    SY_LAST  = SYW'(SCALE_Y - 1);
    localparam logic [UW-1:0]     U_LAST   = UW'(TILE_W - 1);
    localparam logic [VW-1:0]     V_LAST   = VW'(TILE_H - 1);
    localparam logic [ADDR_W-1:0] TW_A     = ADDR_W'(TILE_W);
    localparam logic [ADDR_W-1:0] U_LAST_A = ADDR_W'(TILE_W - 1);

    localparam logic [1:0] MODE_REPEAT = 2'b00;
    localparam logic [1:0] MODE_MIRROR = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    // Raster position and replication / texel counters
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [SXW-1:0]    sx_q, sx_d;
    logic [SYW-1:0]    sy_q, sy_d;
    logic [UW-1:0]     u_q, u_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              tcol_q, tcol_d;
    logic              tcol_zero_q, tcol_zero_d;
    logic              trow_zero_q, trow_zero_d;
    logic [1:0]        mode_q, mode_d;

    // Registered outputs
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              addr_valid_q, addr_valid_d;
    logic              blank_q, blank_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic              eof_q, eof_d;

    logic              at_origin;
    logic              x_last;
    logic              y_last;
    logic [1:0]        em;
    logic [ADDR_W-1:0] u_ext;
    logic [ADDR_W-1:0] u_eff;

    // Effective mode and mirrored texel column for the current pixel
    always_comb begin
        at_origin = (x_q == '0) && (y_q == '0);
        x_last    = (x_q == X_LAST);
        y_last    = (y_q == Y_LAST);
        // The origin pixel uses the live mode so a new frame starts with it.
        em        = at_origin ? mode : mode_q;
        if (em == 2'b11) begin
            em = MODE_REPEAT;
        end
        u_ext = ADDR_W'(u_q);
        u_eff = u_ext;
        if (em == MODE_MIRROR && tcol_q) begin
            u_eff = U_LAST_A - u_ext;
        end
    end

    // Next-state: register the pixel result and advance the raster counters
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        u_d          = u_q;
        v_d          = v_q;
        row_base_d   = row_base_q;
        tcol_d       = tcol_q;
        tcol_zero_d  = tcol_zero_q;
        trow_zero_d  = trow_zero_q;
        mode_d       = mode_q;
        rom_addr_d   = rom_addr_q;
        blank_d      = blank_q;
        addr_valid_d = 1'b0;
        sof_d        = 1'b0;
        eol_d        = 1'b0;
        eof_d        = 1'b0;

        if (enable) begin
            addr_valid_d = 1'b1;
            sof_d        = at_origin;
            eol_d        = x_last;
            eof_d        = x_last && y_last;

            if (em == MODE_SINGLE && !(tcol_zero_q && trow_zero_q)) begin
                rom_addr_d = '0;
                blank_d    = 1'b1;
            end else begin
                rom_addr_d = row_base_q + u_eff;
                blank_d    = 1'b0;
            end

            if (at_origin) begin
                mode_d = mode;
            end

            if (x_last) begin
                // Line wrap discards any partial horizontal tile.
                x_d         = '0;
                sx_d        = '0;
                u_d         = '0;
                tcol_d      = 1'b0;
                tcol_zero_d = 1'b1;
                if (y_last) begin
                    y_d         = '0;
                    sy_d        = '0;
                    v_d         = '0;
                    row_base_d  = '0;
                    trow_zero_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                    if (sy_q == SY_LAST) begin
                        sy_d = '0;
                        if (v_q == V_LAST) begin
                            v_d         = '0;
                            row_base_d  = '0;
                            trow_zero_d = 1'b0;
                        end else begin
                            v_d        = v_q + 1'b1;
                            row_base_d = row_base_q + TW_A;
                        end
                    end else begin
                        sy_d = sy_q + 1'b1;
                    end
                end
            end else begin
                x_d = x_q + 1'b1;
                if (sx_q == SX_LAST) begin
                    sx_d = '0;
                    if (u_q == U_LAST) begin
                        u_d         = '0;
                        tcol_d      = ~tcol_q;
                        tcol_zero_d = 1'b0;
                    end else begin
                        u_d = u_q + 1'b1;
                    end
                end else begin
                    sx_d = sx_q + 1'b1;
                end
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            u_q          <= '0;
            v_q          <= '0;
            row_base_q   <= '0;
            tcol_q       <= 1'b0;
            tcol_zero_q  <= 1'b1;
            trow_zero_q  <= 1'b1;
            mode_q       <= 2'b00;
            rom_addr_q   <= '0;
            addr_valid_q <= 1'b0;
            blank_q      <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            u_q          <= u_d;
            v_q          <= v_d;
            row_base_q   <= row_base_d;
            tcol_q       <= tcol_d;
            tcol_zero_q  <= tcol_zero_d;
            trow_zero_q  <= trow_zero_d;
            mode_q       <= mode_d;
            rom_addr_q   <= rom_addr_d;
            addr_valid_q <= addr_valid_d;
            blank_q      <= blank_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            eof_q        <= eof_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign addr_valid = addr_valid_q;
    assign blank      = blank_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign eof        = eof_q;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Bench for tile_addr_gen: two instances (an unscaled one with truncated edge
// tiles and a 2x2-scaled small one) driven with directed and random
// enable/mode/reset stimulus, compared every cycle against a pixel-coordinate
// reference model.
module tb_tile_addr_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] en;
  logic [1:0] rs;
  logic [1:0] md0;
  logic [1:0] md1;

  logic [6:0] addr0;
  logic [2:0] addr1;
  logic [1:0] av;
  logic [1:0] bl;
  logic [1:0] so;
  logic [1:0] eo;
  logic [1:0] ef;

  tile_addr_gen #(
    .H_ACTIVE(100), .V_ACTIVE(30), .TILE_W(16), .TILE_H(7),
    .SCALE_X(1), .SCALE_Y(1), .ADDR_W(7)
  ) dut0 (
    .clk(clk), .rst(rs[0]), .enable(en[0]), .mode(md0),
    .rom_addr(addr0), .addr_valid(av[0]), .blank(bl[0]),
    .sof(so[0]), .eol(eo[0]), .eof(ef[0])
  );

  tile_addr_gen #(
    .H_ACTIVE(10), .V_ACTIVE(6), .TILE_W(4), .TILE_H(2),
    .SCALE_X(2), .SCALE_Y(2), .ADDR_W(3)
  ) dut1 (
    .clk(clk), .rst(rs[1]), .enable(en[1]), .mode(md1),
    .rom_addr(addr1), .addr_valid(av[1]), .blank(bl[1]),
    .sof(so[1]), .eol(eo[1]), .eof(ef[1])
  );

  // ---------------- geometry of each instance ----------------
  function automatic int g_h(input int i);  return (i == 0) ? 100 : 10; endfunction
  function automatic int g_v(input int i);  return (i == 0) ? 30  : 6;  endfunction
  function automatic int g_tw(input int i); return (i == 0) ? 16  : 4;  endfunction
  function automatic int g_th(input int i); return (i == 0) ? 7   : 2;  endfunction
  function automatic int g_sx(input int i); return (i == 0) ? 1   : 2;  endfunction
  function automatic int g_sy(input int i); return (i == 0) ? 1   : 2;  endfunction
  function automatic int g_aw(input int i); return (i == 0) ? 7   : 3;  endfunction

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  int         px[2];
  int         py[2];
  logic [1:0] fm[2];
  int         e_addr[2];
  logic       e_av[2];
  logic       e_bl[2];
  logic       e_sof[2];
  logic       e_eol[2];
  logic       e_eof[2];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Texel for pixel (x,y) straight from tile arithmetic on pixel coordinates.
  function automatic void ref_pix(input int i, input int x, input int y,
                                  input logic [1:0] m, output int addr,
                                  output logic blk);
    int tx, ty, u, v, tc, tr;
    tx = x / g_sx(i);
    ty = y / g_sy(i);
    u  = tx % g_tw(i);
    tc = tx / g_tw(i);
    v  = ty % g_th(i);
    tr = ty / g_th(i);
    if (m == 2'b01 && (tc % 2) == 1) u = g_tw(i) - 1 - u;
    if (m == 2'b10 && (tc != 0 || tr != 0)) begin
      addr = 0;
      blk  = 1'b1;
    end else begin
      addr = (v * g_tw(i) + u) % (1 << g_aw(i));
      blk  = 1'b0;
    end
  endfunction

  // Predict what the registered outputs become at the coming clock edge.
  task automatic model_cycle(input int i, input logic r, input logic e,
                             input logic [1:0] m);
    logic [1:0] em;
    int a;
    logic b;
    if (r) begin
      px[i] = 0; py[i] = 0; fm[i] = 2'b00;
      e_addr[i] = 0; e_bl[i] = 1'b0;
      e_av[i] = 1'b0; e_sof[i] = 1'b0; e_eol[i] = 1'b0; e_eof[i] = 1'b0;
    end else if (e) begin
      if (px[i] == 0 && py[i] == 0) fm[i] = m;
      em = fm[i];
      if (em == 2'b11) em = 2'b00;
      ref_pix(i, px[i], py[i], em, a, b);
      e_addr[i] = a;
      e_bl[i]   = b;
      e_av[i]   = 1'b1;
      e_sof[i]  = (px[i] == 0 && py[i] == 0);
      e_eol[i]  = (px[i] == g_h(i) - 1);
      e_eof[i]  = e_eol[i] && (py[i] == g_v(i) - 1);
      px[i]++;
      if (px[i] == g_h(i)) begin
        px[i] = 0;
        py[i]++;
        if (py[i] == g_v(i)) py[i] = 0;
      end
    end else begin
      e_av[i] = 1'b0; e_sof[i] = 1'b0; e_eol[i] = 1'b0; e_eof[i] = 1'b0;
    end
  endtask

  task automatic compare(input int i);
    int got_addr;
    got_addr = (i == 0) ? int'(addr0) : int'(addr1);
    check($sformatf("addr_valid%0d", i), int'(av[i]), int'(e_av[i]));
    check($sformatf("rom_addr%0d", i),   got_addr,     e_addr[i]);
    check($sformatf("blank%0d", i),      int'(bl[i]), int'(e_bl[i]));
    check($sformatf("sof%0d", i),        int'(so[i]), int'(e_sof[i]));
    check($sformatf("eol%0d", i),        int'(eo[i]), int'(e_eol[i]));
    check($sformatf("eof%0d", i),        int'(ef[i]), int'(e_eof[i]));
  endtask

  // ---------------- driver ----------------
  // Inputs are already set; predict, clock, then sample 1 ns after the edge.
  task automatic tick();
    model_cycle(0, rs[0], en[0], md0);
    model_cycle(1, rs[1], en[1], md1);
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic run_held(input logic [1:0] m, input int n);
    md0 = m; md1 = m; en = 2'b11; rs = 2'b00;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    en = 2'b00; rs = 2'b11; md0 = 2'b00; md1 = 2'b00;
    #1;
    tick();
    tick();
    rs = 2'b00;

    // Held enable, one full frame of instance 0 per mode (many of instance 1).
    // A mode change only shows from the following frame start.
    run_held(2'b00, 3010);
    run_held(2'b01, 3010);
    run_held(2'b10, 3010);
    run_held(2'b11, 3010);

    // Enable toggled 1-0-0-1 so outputs must hold across the gaps.
    md0 = 2'b01; md1 = 2'b01;
    for (int k = 0; k < 400; k++) begin
      en = ((k % 3) == 0) ? 2'b11 : 2'b00;
      tick();
    end

    // Random enable, mode changes mid-frame and occasional mid-frame resets.
    for (int k = 0; k < 12000; k++) begin
      en[0] = ($urandom_range(0, 3) != 0);
      en[1] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) md0 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0)  md1 = 2'($urandom_range(0, 3));
      rs[0] = ($urandom_range(0, 1999) == 0);
      rs[1] = ($urandom_range(0, 499) == 0);
      tick();
    end
    rs = 2'b00;
    run_held(2'b00, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
